// File: rtl/npu_mem_byte_seq.sv
// npu_mem_byte_seq: sequences 32-bit word requests into four byte accesses
// on a 2048x8 synchronous-read RAM and reassembles the read bytes.
module npu_mem_byte_seq #(
    parameter int unsigned         MEMSEL_W = 6,
    parameter int unsigned         REGSEL_W = 14,
    parameter logic [MEMSEL_W-1:0] MEM_ADDR = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [MEMSEL_W-1:0] req_memsel,
    input  logic [REGSEL_W-1:0] req_addr,
    input  logic [3:0]          req_be,
    input  logic [31:0]         req_wdata,
    output logic                rsp_valid,
    output logic                rsp_err,
    output logic [31:0]         rsp_rdata,
    output logic [MEMSEL_W-1:0] mem_adr,
    output logic [REGSEL_W-1:0] reg_adr,
    output logic [7:0]          din,
    output logic                we,
    input  logic [7:0]          dout
);

    typedef enum logic [2:0] {IDLE, WR, RD, RDLAST, RESP} state_t;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d, cnt_nxt;
    logic [REGSEL_W-3:0]   waddr_q, waddr_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [23:0]           rdata_q, rdata_d;
    logic [MEMSEL_W-1:0]   mem_adr_q, mem_adr_d;
    logic [REGSEL_W-1:0]   reg_adr_q, reg_adr_d;
    logic [7:0]            din_q, din_d;
    logic                  we_q, we_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;

    // Word alignment makes the low address bits irrelevant.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^req_addr[1:0];

    assign req_ready = (state_q == IDLE);
    assign mem_adr   = mem_adr_q;
    assign reg_adr   = reg_adr_q;
    assign din       = din_q;
    assign we        = we_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    // Next-state and registered-output logic; RAM bus values are computed one
    // cycle ahead so the byte for cnt appears while the FSM sits at cnt.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cnt_nxt     = cnt_q + 2'd1;
        waddr_d     = waddr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        mem_adr_d   = mem_adr_q;
        reg_adr_d   = reg_adr_q;
        din_d       = din_q;
        we_d        = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    waddr_d = req_addr[REGSEL_W-1:2];
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    cnt_d   = 2'd0;
                    rdata_d = '0;
                    if (req_memsel != MEM_ADDR) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        mem_adr_d = req_memsel;
                        reg_adr_d = {req_addr[REGSEL_W-1:2], 2'd0};
                        if (req_we) begin
                            state_d = WR;
                            din_d   = req_wdata[7:0];
                            we_d    = req_be[0];
                        end else begin
                            state_d = RD;
                            din_d   = '0;
                        end
                    end
                end
            end
            WR: begin
                if (cnt_q == 2'd3) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d     = cnt_nxt;
                    reg_adr_d = {waddr_q, cnt_nxt};
                    din_d     = wdata_q[{cnt_nxt, 3'b000} +: 8];
                    we_d      = be_q[cnt_nxt];
                end
            end
            RD: begin
                // dout lags the address by one cycle, so cnt k returns byte k-1.
                unique case (cnt_q)
                    2'd1:    rdata_d[7:0]   = dout;
                    2'd2:    rdata_d[15:8]  = dout;
                    2'd3:    rdata_d[23:16] = dout;
                    default: ;
                endcase
                if (cnt_q == 2'd3) begin
                    state_d = RDLAST;
                end else begin
                    cnt_d     = cnt_nxt;
                    reg_adr_d = {waddr_q, cnt_nxt};
                    din_d     = '0;
                end
            end
            RDLAST: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = {dout, rdata_q};
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            waddr_q     <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_adr_q   <= '0;
            reg_adr_q   <= '0;
            din_q       <= '0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            waddr_q     <= waddr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mem_adr_q   <= mem_adr_d;
            reg_adr_q   <= reg_adr_d;
            din_q       <= din_d;
            we_q        <= we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_npu_mem_byte_seq.sv
// Testbench for npu_mem_byte_seq: transaction-level model plus per-cycle compare.
module tb_npu_mem_byte_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [5:0]  req_memsel = '0;
    logic [13:0] req_addr = '0;
    logic [3:0]  req_be = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [5:0]  mem_adr;
    logic [13:0] reg_adr;
    logic [7:0]  din;
    logic        we;
    logic [7:0]  dout;

    int checks = 0;
    int errors = 0;
    int e = 0;

    // Current transaction as seen by the model
    logic        t_active = 1'b0;
    int          t_acc = 0;
    int          t_len = 0;
    logic        t_we = 1'b0;
    logic        t_err = 1'b0;
    logic [13:0] t_addr = '0;
    logic [3:0]  t_be = '0;
    logic [31:0] t_wdata = '0;
    logic [31:0] t_rdata = '0;
    logic [31:0] hold_rdata = '0;
    logic [7:0]  model_mem [0:2047];

    always #5 clk = ~clk;

    npu_mem_byte_seq #(
        .MEMSEL_W(6),
        .REGSEL_W(14),
        .MEM_ADDR(6'b000000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_memsel(req_memsel), .req_addr(req_addr), .req_be(req_be),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_adr(mem_adr), .reg_adr(reg_adr), .din(din), .we(we), .dout(dout)
    );

    // 2048x8 RAM with one-cycle synchronous read
    logic [7:0] ram [0:2047];
    logic [7:0] ram_dout = '0;
    assign dout = ram_dout;
    always @(posedge clk) begin
        if (we && mem_adr == 6'd0) ram[reg_adr[10:0]] <= din;
        ram_dout <= ram[reg_adr[10:0]];
    end

    always @(posedge clk) e <= e + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the transaction model
    always @(negedge clk) begin : cmp
        int k;
        int b;
        logic exp_valid;
        logic exp_ready;
        if (!rst_n) begin
            hold_rdata = '0;
        end else begin
            k = t_active ? (e - t_acc + 1) : 0;
            exp_ready = !(t_active && k >= 1 && k <= t_len);
            exp_valid = t_active && (k == t_len);
            if (exp_valid) hold_rdata = t_rdata;
            check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
            if (exp_valid) check("rsp_err", {31'd0, rsp_err}, {31'd0, t_err});
            check("rsp_rdata", rsp_rdata, hold_rdata);
            if (t_active && !t_err && k >= 1 && k <= 4) begin
                b = k - 1;
                check("reg_adr", {18'd0, reg_adr}, {18'd0, t_addr[13:2], 2'(b)});
                check("mem_adr", {26'd0, mem_adr}, 32'd0);
                check("we", {31'd0, we}, {31'd0, t_we & t_be[b]});
                check("din", {24'd0, din}, t_we ? {24'd0, t_wdata[8*b +: 8]} : 32'd0);
            end else begin
                check("we_idle", {31'd0, we}, 32'd0);
            end
        end
    end

    // Present a request and hold it until accepted; updates the model at acceptance.
    task automatic do_req(input logic w, input logic [5:0] ms, input logic [13:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
        int n;
        logic [31:0] rd;
        @(negedge clk);
        req_valid = 1'b1; req_we = w; req_memsel = ms; req_addr = a;
        req_be = be; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        rd = '0;
        if (ms == 6'd0) begin
            for (int i = 0; i < 4; i++) begin
                if (w) begin
                    if (be[i]) model_mem[{a[10:2], 2'(i)}] = wd[8*i +: 8];
                end else begin
                    rd[8*i +: 8] = model_mem[{a[10:2], 2'(i)}];
                end
            end
        end
        t_acc = e; t_we = w; t_err = (ms != 6'd0); t_addr = a; t_be = be;
        t_wdata = wd; t_rdata = rd;
        t_len = t_err ? 1 : (w ? 5 : 6);
        t_active = 1'b1;
    endtask

    // Full transaction; returns at the negedge of the response cycle.
    task automatic txn(input logic w, input logic [5:0] ms, input logic [13:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
        do_req(w, ms, a, be, wd);
        req_valid = 1'b0;
        repeat (t_len) @(negedge clk);
        #1;
    endtask

    initial begin
        #2;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_reg_adr", {18'd0, reg_adr}, 32'd0);
        check("rst_mem_adr", {26'd0, mem_adr}, 32'd0);
        check("rst_din", {24'd0, din}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        txn(1'b1, 6'd0, 14'h104, 4'hF, 32'hA1B2C3D4);
        check("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
        txn(1'b0, 6'd0, 14'h104, 4'h0, 32'h0);
        check("rd_full", rsp_rdata, 32'hA1B2C3D4);

        txn(1'b1, 6'd0, 14'h104, 4'b0101, 32'h11223344);
        txn(1'b0, 6'd0, 14'h104, 4'h0, 32'h0);
        check("rd_partial", rsp_rdata, 32'hA122C344);

        txn(1'b1, 6'd1, 14'h104, 4'hF, 32'hFFFFFFFF);
        check("err_valid", {31'd0, rsp_valid}, 32'd1);
        check("err_flag", {31'd0, rsp_err}, 32'd1);
        check("err_rdata", rsp_rdata, 32'd0);
        txn(1'b0, 6'd0, 14'h104, 4'h0, 32'h0);
        check("rd_after_err", rsp_rdata, 32'hA122C344);

        // Back-to-back: second request held while the first is in flight
        do_req(1'b1, 6'd0, 14'h7FC, 4'hF, 32'hDEADBEEF);
        do_req(1'b0, 6'd0, 14'h7FC, 4'h0, 32'h0);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("rd_top", rsp_rdata, 32'hDEADBEEF);

        txn(1'b1, 6'd0, 14'h104, 4'b0000, 32'h55555555);
        txn(1'b0, 6'd0, 14'h104, 4'h0, 32'h0);
        check("rd_be0", rsp_rdata, 32'hA122C344);

        txn(1'b1, 6'd0, 14'h2808, 4'hF, 32'h0BADF00D);
        txn(1'b0, 6'd0, 14'h2808, 4'h0, 32'h0);
        check("rd_upper", rsp_rdata, 32'h0BADF00D);

        // Reset during RD cnt=2
        do_req(1'b0, 6'd0, 14'h104, 4'h0, 32'h0);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        t_active = 1'b0;
        check("mid_rst_we", {31'd0, we}, 32'd0);
        check("mid_rst_reg_adr", {18'd0, reg_adr}, 32'd0);
        check("mid_rst_din", {24'd0, din}, 32'd0);
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        repeat (10) @(negedge clk);

        txn(1'b0, 6'd0, 14'h104, 4'h0, 32'h0);
        check("rd_after_rst", rsp_rdata, 32'hA122C344);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/npu_mem_byte_seq.md
Name: npu_mem_byte_seq

Overview:
- Upstream access sequencer for the 2048x8 NPU byte memory.
- Takes 32-bit word read/write requests from the NPU/AHB side over a valid/ready handshake.
- Breaks each request into four byte accesses on the memory's mem_adr/reg_adr/din/we interface, and reassembles read bytes into one 32-bit response.
- Handles the memory's one-cycle synchronous read latency, byte enables, and rejection of requests aimed at a different memory.

Parameters:
- MEMSEL_W, 6: width of the memory-select field.
- REGSEL_W, 14: width of the register/byte address field.
- MEM_ADDR, 6'b000000: memory-select value owned by the attached RAM.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_memsel  in  MEMSEL_W  target memory select.
- req_addr  in  REGSEL_W  byte address; bits [1:0] ignored (word aligned).
- req_be  in  4  byte enables for writes; bit i covers byte i; ignored on reads.
- req_wdata  in  32  write data, little-endian (byte i = bits [8i+7:8i]).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  1  qualifies rsp_valid: request rejected.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- mem_adr  out  MEMSEL_W  to RAM mem_adr.
- reg_adr  out  REGSEL_W  to RAM reg_adr.
- din  out  8  to RAM din.
- we  out  1  to RAM we, active high.
- dout  in  8  from RAM dout; valid the cycle after the address is presented.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE, byte counter to 0.
  - Outputs: mem_adr=0, reg_adr=0, din=0, we=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - Reset mid-transaction aborts it with no response; bytes already written stay written.
- Ready: req_ready = (state==IDLE), combinational from state. It is 1 out of reset.
- On acceptance, latch we, memsel, word address, be and wdata.
  - Request inputs are don't-care afterwards until the next acceptance.
- Memory-select check at acceptance:
  - If req_memsel != MEM_ADDR, go to RESP with rsp_err=1 and rsp_rdata=0.
  - No memory cycle is issued and we stays 0.
  - Response is 1 cycle after acceptance.
- States:
  - IDLE
    - we=0; mem_adr/reg_adr/din hold their last values.
    - Exits to WR, RD or RESP on acceptance.
  - WR (4 cycles, cnt=0..3)
    - Drive reg_adr={addr[REGSEL_W-1:2],cnt}, mem_adr=memsel, din=wdata byte cnt, we=be[cnt].
    - A disabled byte still spends its cycle with we=0 (a harmless read).
    - After cnt=3, go to RESP.
  - RD (4 cycles, cnt=0..3)
    - Drive reg_adr as in WR, with we=0 and din=0.
    - In cycles cnt=1..3, capture dout into rdata byte cnt-1.
    - After cnt=3, go to RDLAST.
  - RDLAST (1 cycle)
    - Capture dout into byte 3; we=0.
    - Then go to RESP.
  - RESP (1 cycle)
    - rsp_valid=1, with rsp_err and rsp_rdata registered (write: rdata=0, err=0).
    - Then go to IDLE.
- Latency, with acceptance at edge 0:
  - Write: bytes on cycles 1–4, rsp_valid on cycle 5.
  - Read: addresses on cycles 1–4, rsp_valid on cycle 6.
  - Error: rsp_valid on cycle 1.
  - Next acceptance is possible the cycle after RESP; there is no overlap between requests.
- rsp_valid is a pulse with no backpressure; the consumer must accept it.
  - rsp_rdata holds its value until the next response.
- Addressing:
  - Byte address is the low 2 bits = cnt. The word address is never incremented, so there is no carry into upper bits.
  - The word at the top of the range (addr[10:2]=all ones) uses bytes 0x7FC–0x7FF; there is no wrap.
  - reg_adr bits above [10] pass through unchanged.
- Write with be=4'b0000 takes the full 4 cycles with we never asserted, then responds normally.
- we, din, reg_adr and mem_adr are registered outputs: no combinational path from req_* to the RAM.

Test Plan:
- Write addr=0x104, be=4'hF, wdata=0xA1B2C3D4 → cycles 1–4 show reg_adr 0x104..0x107 with din D4,C3,B2,A1 and we=1; rsp_valid on cycle 5 with err=0.
- Read back addr=0x104 → rsp_valid on cycle 6 with rsp_rdata=0xA1B2C3D4; we=0 throughout.
- Write addr=0x104, be=4'b0101, wdata=0x11223344, then read → rdata=0xA122C344.
- Request with req_memsel=6'h01 ≠ MEM_ADDR → no we pulse; rsp_valid=1 and rsp_err=1 on cycle 1, rdata=0.
- Write 0xDEADBEEF to addr=0x7FC, then read → reg_adr 0x7FC..0x7FF and rdata=0xDEADBEEF; also drive back-to-back req_valid and check req_ready=0 until after RESP.
- Assert rst_n=0 during RD cnt=2 → outputs return to reset values immediately, no rsp_valid, and req_ready=1 after release.
